// File: rtl/chap1_pkg.sv
// Shared types and constants for the count checker: FSM state encoding and
// error-statistics counter sizing.
package chap1_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int                   ERR_CNT_W   = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

   // Match and miss run lengths top out at 15.
   localparam int                   RUN_CNT_W   = 4;

endpackage

// File: rtl/chap1_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the match/miss run
// lengths and for the optional error total.
module chap1_sat_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/chap1_count_checker.sv
// Up-counter sequence checker: hunts, syncs on LOCK_CNT matches, then
// flywheels in LOCKED. Define CHAP1_CHECKER_STATS_EN to add the ErrCount port.
module chap1_count_checker
   import chap1_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int LOCK_CNT   = 4,
   parameter int MISS_LIMIT = 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     CountIn,
   input  logic                 CountValid,
   output logic                 Locked,
   output logic                 ErrPulse,
   output logic [WIDTH-1:0]     Expected
`ifdef CHAP1_CHECKER_STATS_EN
   ,
   output logic [ERR_CNT_W-1:0] ErrCount
`endif
);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [WIDTH-1:0]       r_expected;
   logic [WIDTH-1:0]       w_expected_next;
   logic                   r_locked;
   logic                   r_err_pulse;
   logic                   w_err_next;

   logic [RUN_CNT_W-1:0]   w_match_cnt;
   logic [RUN_CNT_W-1:0]   w_miss_cnt;
   logic                   w_match_clr;
   logic                   w_match_inc;
   logic                   w_miss_clr;
   logic                   w_miss_inc;

   logic                   w_sample_match;
   logic                   w_lock_hit;
   logic                   w_miss_hit;

   assign w_sample_match = (CountIn == r_expected);
   // Current sample would bring the run to its threshold.
   assign w_lock_hit     = ((w_match_cnt + 1'b1) == RUN_CNT_W'(LOCK_CNT));
   assign w_miss_hit     = ((w_miss_cnt + 1'b1) == RUN_CNT_W'(MISS_LIMIT));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= HUNT;
         r_expected  <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_expected  <= w_expected_next;
         r_locked    <= (w_state_next == LOCKED);
         r_err_pulse <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (CountValid) begin
         case (r_state)
            HUNT:    w_state_next = SYNC;
            SYNC:    if (w_sample_match && w_lock_hit) w_state_next = LOCKED;
            LOCKED:  if (!w_sample_match && w_miss_hit) w_state_next = HUNT;
            default: w_state_next = HUNT;
         endcase
      end
   end

   always_comb begin
      w_expected_next = r_expected;
      w_err_next      = 1'b0;
      w_match_clr     = 1'b0;
      w_match_inc     = 1'b0;
      w_miss_clr      = 1'b0;
      w_miss_inc      = 1'b0;
      if (CountValid) begin
         case (r_state)
            HUNT: begin
               w_expected_next = CountIn + 1'b1;
               w_match_clr     = 1'b1;
            end
            SYNC: begin
               w_expected_next = CountIn + 1'b1;
               if (w_sample_match) begin
                  w_match_inc = 1'b1;
                  w_miss_clr  = w_lock_hit;
               end else begin
                  w_match_clr = 1'b1;
               end
            end
            LOCKED: begin
               // Flywheel: never resync to CountIn once locked.
               w_expected_next = r_expected + 1'b1;
               if (w_sample_match) begin
                  w_miss_clr = 1'b1;
               end else begin
                  w_err_next = 1'b1;
                  w_miss_clr = w_miss_hit;
                  w_miss_inc = !w_miss_hit;
               end
            end
            default: ;
         endcase
      end
   end

   chap1_sat_counter #(
      .WIDTH (RUN_CNT_W),
      .MAX   ('1)
   ) u_match_cnt (
      .i_clk   (Clk),
      .i_srst  (Reset),
      .i_clr   (w_match_clr),
      .i_inc   (w_match_inc),
      .o_count (w_match_cnt)
   );

   chap1_sat_counter #(
      .WIDTH (RUN_CNT_W),
      .MAX   ('1)
   ) u_miss_cnt (
      .i_clk   (Clk),
      .i_srst  (Reset),
      .i_clr   (w_miss_clr),
      .i_inc   (w_miss_inc),
      .o_count (w_miss_cnt)
   );

`ifdef CHAP1_CHECKER_STATS_EN
   // Counts alongside the registered ErrPulse so both update on the same edge.
   chap1_sat_counter #(
      .WIDTH (ERR_CNT_W),
      .MAX   (ERR_CNT_MAX)
   ) u_err_cnt (
      .i_clk   (Clk),
      .i_srst  (Reset),
      .i_clr   (1'b0),
      .i_inc   (w_err_next),
      .o_count (ErrCount)
   );
`endif

   assign Locked   = r_locked;
   assign ErrPulse = r_err_pulse;
   assign Expected = r_expected;

endmodule

// File: tb/tb_chap1_count_checker.sv
// Scoreboard bench for chap1_count_checker: directed scenarios plus random
// traffic, predicted by a rule-level model. Honours CHAP1_CHECKER_STATS_EN.
module tb_chap1_count_checker;

   localparam int WIDTH    = 4;
   localparam int LOCK_CNT = 4;
`ifdef CHAP1_CHECKER_STATS_EN
   localparam int MISS_LIMIT = 15;
`else
   localparam int MISS_LIMIT = 2;
`endif
   localparam int MOD = 1 << WIDTH;

   localparam int M_HUNT   = 0;
   localparam int M_SYNC   = 1;
   localparam int M_LOCKED = 2;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic [WIDTH-1:0] CountIn = '0;
   logic             CountValid = 1'b0;
   logic             Locked;
   logic             ErrPulse;
   logic [WIDTH-1:0] Expected;
`ifdef CHAP1_CHECKER_STATS_EN
   logic [7:0]       ErrCount;
`endif

   chap1_count_checker #(
      .WIDTH      (WIDTH),
      .LOCK_CNT   (LOCK_CNT),
      .MISS_LIMIT (MISS_LIMIT)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .CountIn    (CountIn),
      .CountValid (CountValid),
      .Locked     (Locked),
      .ErrPulse   (ErrPulse),
      .Expected   (Expected)
`ifdef CHAP1_CHECKER_STATS_EN
      ,
      .ErrCount   (ErrCount)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit locked;
      bit err;
      int exp;
      int ec;
   } resp_t;

   resp_t q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_txn    = 0;

   // Reference model state
   int m_st    = M_HUNT;
   int m_exp   = 0;
   int m_match = 0;
   int m_miss  = 0;
   int m_ec    = 0;

   task automatic model_step(input bit rst, input bit v, input int cin);
      resp_t r;
      bit    err;
      err = 0;
      if (rst) begin
         m_st = M_HUNT; m_exp = 0; m_match = 0; m_miss = 0; m_ec = 0;
      end else if (v) begin
         if (m_st == M_HUNT) begin
            m_exp = (cin + 1) % MOD;
            m_match = 0;
            m_st = M_SYNC;
         end else if (m_st == M_SYNC) begin
            if (cin == m_exp) begin
               m_match++;
               if (m_match == LOCK_CNT) begin
                  m_st = M_LOCKED;
                  m_miss = 0;
               end
            end else begin
               m_match = 0;
            end
            m_exp = (cin + 1) % MOD;
         end else begin
            if (cin == m_exp) begin
               m_miss = 0;
            end else begin
               err = 1;
               m_miss++;
               if (m_ec < 255) m_ec++;
               if (m_miss == MISS_LIMIT) begin
                  m_st = M_HUNT;
                  m_miss = 0;
               end
            end
            m_exp = (m_exp + 1) % MOD;
         end
      end
      r.locked = (m_st == M_LOCKED);
      r.err    = err;
      r.exp    = m_exp;
      r.ec     = m_ec;
      q.push_back(r);
   endtask

   task automatic step(input bit rst, input bit v, input int cin);
      @(negedge Clk);
      Reset      = rst;
      CountValid = v;
      CountIn    = WIDTH'(cin);
      model_step(rst, v, cin);
   endtask

   task automatic drive_seq(input int start, input int n);
      for (int i = 0; i < n; i++) step(0, 1, (start + i) % MOD);
   endtask

   // Monitor: the DUT presents a registered response every cycle
   always @(posedge Clk) begin
      resp_t r;
      #1;
      if (q.size() > 0) begin
         r = q.pop_front();
         n_txn++;
         $display("txn %0d: Locked=%0d ErrPulse=%0d Expected=%0d", n_txn, Locked, ErrPulse, Expected);
         n_checks++;
         if (Locked !== r.locked) begin
            n_fail++;
            $display("FAIL locked txn=%0d got=%0d exp=%0d", n_txn, Locked, r.locked);
         end
         n_checks++;
         if (ErrPulse !== r.err) begin
            n_fail++;
            $display("FAIL errpulse txn=%0d got=%0d exp=%0d", n_txn, ErrPulse, r.err);
         end
         n_checks++;
         if (Expected !== WIDTH'(r.exp)) begin
            n_fail++;
            $display("FAIL expected txn=%0d got=%0d exp=%0d", n_txn, Expected, r.exp);
         end
`ifdef CHAP1_CHECKER_STATS_EN
         n_checks++;
         if (ErrCount !== 8'(r.ec)) begin
            n_fail++;
            $display("FAIL errcount txn=%0d got=%0d exp=%0d", n_txn, ErrCount, r.ec);
         end
`endif
      end
   end

   initial begin
      int src;
      int errs;
      int k;

      // Reset, then lock acquisition on 0..4
      step(1, 0, 0);
      step(1, 0, 0);
      drive_seq(0, 5);
      // Run up through the wrap 14,15,0,1
      drive_seq(5, 13);
      // Expected=5 then error 7, recover with 6
      drive_seq(2, 3);
      step(0, 1, 7);
      step(0, 1, 6);
      // Advance to Expected=3, then two misses
      drive_seq(7, 12);
      step(0, 1, 9);
      step(0, 1, 9);
      // Relock, hold through a valid gap, then reset during lock
      drive_seq(0, 5);
      for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, MOD - 1));
      step(1, 1, 9);
      step(0, 0, 0);
      // Reset colliding with an error cycle
      drive_seq(3, 5);
      step(1, 1, 0);
      step(0, 0, 0);

      // Random traffic: a counter with occasional glitches, gaps and resets
      src = $urandom_range(0, MOD - 1);
      for (int i = 0; i < 2000; i++) begin
         bit v;
         bit rst;
         int val;
         rst = ($urandom_range(0, 199) == 0);
         v   = ($urandom_range(0, 3) != 0);
         val = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, MOD - 1)) : src;
         step(rst, v, val);
         if (v) src = (src + 1) % MOD;
      end

      // Error-total stress: repeated relock followed by MISS_LIMIT misses
      step(1, 0, 0);
      errs = 0;
      while (errs < 300) begin
         drive_seq(0, LOCK_CNT + 1);
         for (int i = 0; i < MISS_LIMIT; i++) step(0, 1, (m_exp + 8) % MOD);
         errs += MISS_LIMIT;
      end
      step(0, 0, 0);

      k = 0;
      while (q.size() > 0 && k < 10) begin
         @(posedge Clk);
         k++;
      end
      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending got=%0d exp=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
